// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package sevenseg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low g..a patterns for hex 0..F; bit 7 (dp) is left off.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Value-load handshake, live display controls and display pins of the scan controller.
interface sevenseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value;
  logic                    value_valid;
  logic                    value_ready;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              seg;
  logic                    frame_done;

  modport master (
    output value, value_valid, blank_lz, dp_mask,
    input  value_ready, an, seg, frame_done
  );

  modport slave (
    input  value, value_valid, blank_lz, dp_mask,
    output value_ready, an, seg, frame_done
  );

endinterface

// File: rtl/sevenseg_scan_ctrl_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module hex_digit_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] segs_o
);

  assign segs_o = SEG_LUT[nibble_i][6:0];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scanner with guard blanking,
// leading-zero suppression, per-digit dp and a frame-synchronous value load.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 1000,
  parameter int BLANK_TICKS     = 8
) (
  input logic                 clock,
  input logic                 reset,
  sevenseg_scan_ctrl_if.slave bus
);

  localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0] BLANK_LEN  = TW'(BLANK_TICKS);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [VW-1:0]         display_q, display_d;
  logic [VW-1:0]         pending_q, pending_d;
  logic                  pend_full_q, pend_full_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end;
  logic                  boundary;
  logic                  xfer;
  logic                  zeros_above;
  logic [NUM_DIGITS-1:0] lz_supp;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_segs;

  assign slot_end = (tick_q == TICK_LAST);
  assign boundary = slot_end && (digit_q == DIGIT_LAST);
  assign xfer     = bus.value_valid && !pend_full_q;

  always_comb begin
    tick_d  = tick_q + 1'b1;
    digit_d = digit_q;
    if (slot_end) begin
      tick_d  = '0;
      digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
    end
  end

  // With no guard interval the scanner stays in SHOW across slot boundaries.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (tick_d >= BLANK_LEN) state_d = SHOW;
      SHOW:    if (slot_end && (BLANK_TICKS > 0)) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // The pending value only reaches the display at the frame boundary, so a
  // frame is never torn; a load landing on the boundary waits one frame more.
  always_comb begin
    display_d   = display_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    if (boundary && pend_full_q) begin
      display_d   = pending_q;
      pend_full_d = 1'b0;
    end else if (xfer) begin
      pending_d   = bus.value;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    zeros_above = 1'b1;
    lz_supp     = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zeros_above = zeros_above && (display_d[4*i +: 4] == 4'h0);
      lz_supp[i]  = bus.blank_lz && zeros_above;
    end
  end

  assign cur_nibble = display_d[{digit_d, 2'b00} +: 4];

  hex_digit_decode u_decode (
    .nibble_i (cur_nibble),
    .segs_o   (cur_segs)
  );

  // Outputs are computed from next-state values so the registered pins
  // change on the same edge as the slot/state they describe.
  always_comb begin
    an_d         = '1;
    seg_d        = SEG_OFF;
    frame_done_d = boundary;
    if ((state_d == SHOW) && !lz_supp[digit_d]) begin
      an_d[digit_d] = 1'b0;
      seg_d         = {~bus.dp_mask[digit_d], cur_segs};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= BLANK;
      tick_q       <= '0;
      digit_q      <= '0;
      display_q    <= '0;
      pending_q    <= '0;
      pend_full_q  <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      digit_q      <= digit_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      pend_full_q  <= pend_full_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.value_ready = !pend_full_q;
  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl: per-cycle scoreboard model,
// table-driven display vectors and hand-written handshake/reset sequences.
module tb_sevenseg_scan_ctrl;

  localparam int ND    = 4;
  localparam int TPD   = 10;
  localparam int BT    = 2;
  localparam int FRAME = ND * TPD;

  localparam logic [7:0] REF_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic       fd;
    logic       rdy;
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic [3:0]  dp;
    logic [31:0] expSegs;
    logic [3:0]  expOn;
  } vec_t;

  logic clock;
  logic reset;
  int   checkCount;
  int   errorCount;

  exp_t        expQ [$];
  int          mCyc;
  logic [15:0] mDisp;
  logic [15:0] mPendVal;
  logic        mPend;

  vec_t vecs [8];

  sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_scan_ctrl #(
    .NUM_DIGITS      (ND),
    .TICKS_PER_DIGIT (TPD),
    .BLANK_TICKS     (BT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v);
    int n;
    n = 0;
    bus.value       = v;
    bus.value_valid = 1'b1;
    while (!bus.value_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("loadReady", 32'(bus.value_ready), 32'd1);
    @(negedge clock);
    bus.value_valid = 1'b0;
  endtask

  task automatic waitFrame();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.frame_done && n < 2 * FRAME);
    checkOutput("frameSeen", 32'(bus.frame_done), 32'd1);
  endtask

  // Reference model: position in the frame is derived from a cycle count
  // since reset release; expected outputs are queued for the cycle just entered.
  always @(posedge clock or posedge reset) begin : modelStep
    exp_t e;
    int   pos, d, t;
    logic supp, xfer;
    if (reset) begin
      mCyc     = 0;
      mDisp    = '0;
      mPendVal = '0;
      mPend    = 1'b0;
      expQ.delete();
    end else begin
      xfer = bus.value_valid && !mPend;
      mCyc++;
      pos = mCyc % FRAME;
      d   = pos / TPD;
      t   = pos % TPD;
      if (pos == 0 && mPend) begin
        mDisp = mPendVal;
        mPend = 1'b0;
      end else if (xfer) begin
        mPendVal = bus.value;
        mPend    = 1'b1;
      end
      supp  = bus.blank_lz && (d > 0) && ((mDisp >> (4 * d)) == 16'h0);
      e.fd  = (pos == 0);
      e.rdy = !mPend;
      e.an  = 4'hF;
      e.seg = 8'hFF;
      if (t >= BT && !supp) begin
        e.an[d] = 1'b0;
        e.seg   = {~bus.dp_mask[d], REF_SEG[mDisp[4*d +: 4]][6:0]};
      end
      expQ.push_back(e);
    end
  end

  always @(posedge clock) begin : sbCheck
    exp_t want;
    #1;
    if (!reset && expQ.size() > 0) begin
      want = expQ.pop_front();
      checkOutput($sformatf("sb_cyc%0d", mCyc),
                  32'({bus.frame_done, bus.value_ready, bus.an, bus.seg}), 32'(want));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount      = 0;
    errorCount      = 0;
    reset           = 1'b1;
    bus.value       = '0;
    bus.value_valid = 1'b0;
    bus.blank_lz    = 1'b0;
    bus.dp_mask     = '0;

    vecs[0] = '{16'h12AF, 1'b0, 4'b0000, 32'hF9A4888E, 4'b1111};
    vecs[1] = '{16'h0030, 1'b1, 4'b0000, 32'hFFFFB0C0, 4'b0011};
    vecs[2] = '{16'h0000, 1'b1, 4'b0000, 32'hFFFFFFC0, 4'b0001};
    vecs[3] = '{16'h12AF, 1'b0, 4'b0010, 32'hF9A4088E, 4'b1111};
    vecs[4] = '{16'h0000, 1'b0, 4'b0000, 32'hC0C0C0C0, 4'b1111};
    vecs[5] = '{16'h0905, 1'b1, 4'b1111, 32'hFF104012, 4'b0111};
    vecs[6] = '{16'h8421, 1'b1, 4'b0101, 32'h8019A479, 4'b1111};
    vecs[7] = '{16'h0030, 1'b0, 4'b1000, 32'h40C0B0C0, 4'b1111};

    #12;
    checkOutput("rstAn", 32'(bus.an), 32'hF);
    checkOutput("rstSeg", 32'(bus.seg), 32'hFF);
    checkOutput("rstFd", 32'(bus.frame_done), 32'd0);
    checkOutput("rstReady", 32'(bus.value_ready), 32'd1);

    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c <= 41; c++) begin
      if (c == 0 || c == 1) begin
        checkOutput($sformatf("startBlankAn_c%0d", c), 32'(bus.an), 32'hF);
        checkOutput($sformatf("startBlankSeg_c%0d", c), 32'(bus.seg), 32'hFF);
      end
      if (c == 2 || c == 9) begin
        checkOutput($sformatf("startD0An_c%0d", c), 32'(bus.an), 32'hE);
        checkOutput($sformatf("startD0Seg_c%0d", c), 32'(bus.seg), 32'hC0);
      end
      if (c == 12) begin
        checkOutput("startD1An", 32'(bus.an), 32'hD);
        checkOutput("startD1Seg", 32'(bus.seg), 32'hC0);
      end
      if (c == 39 || c == 40 || c == 41)
        checkOutput($sformatf("firstFd_c%0d", c), 32'(bus.frame_done), (c == 40) ? 32'd1 : 32'd0);
      @(negedge clock);
    end

    repeat (10) @(negedge clock);
    checkOutput("hsReadyBefore", 32'(bus.value_ready), 32'd1);
    bus.value       = 16'h12AF;
    bus.value_valid = 1'b1;
    @(negedge clock);
    bus.value_valid = 1'b0;
    checkOutput("hsReadyDrop", 32'(bus.value_ready), 32'd0);
    waitFrame();
    checkOutput("hsReadyBoundary", 32'(bus.value_ready), 32'd1);
    repeat (5) @(negedge clock);
    checkOutput("hsNewD0An", 32'(bus.an), 32'hE);
    checkOutput("hsNewD0Seg", 32'(bus.seg), 32'h8E);

    begin : backToBack
      int n;
      bus.value       = 16'h0030;
      bus.value_valid = 1'b1;
      @(negedge clock);
      bus.value = 16'h8421;
      checkOutput("b2bReadyDrop", 32'(bus.value_ready), 32'd0);
      n = 0;
      while (!bus.value_ready && n < 2 * FRAME) begin
        @(negedge clock);
        n++;
      end
      checkOutput("b2bReadyBack", 32'(bus.value_ready), 32'd1);
      checkOutput("b2bBoundary", 32'(bus.frame_done), 32'd1);
      @(negedge clock);
      bus.value_valid = 1'b0;
      checkOutput("b2bSecondTaken", 32'(bus.value_ready), 32'd0);
      repeat (14) @(negedge clock);
      checkOutput("b2bFirstAn", 32'(bus.an), 32'hD);
      checkOutput("b2bFirstSeg", 32'(bus.seg), 32'hB0);
      waitFrame();
      repeat (5) @(negedge clock);
      checkOutput("b2bSecondAn", 32'(bus.an), 32'hE);
      checkOutput("b2bSecondSeg", 32'(bus.seg), 32'hF9);
    end

    for (int k = 0; k < 8; k++) begin
      bus.blank_lz = vecs[k].blz;
      bus.dp_mask  = vecs[k].dp;
      applyStimulus(vecs[k].value);
      waitFrame();
      waitFrame();
      for (int d = 0; d < ND; d++) begin
        logic [3:0] expAn;
        expAn = 4'hF;
        if (vecs[k].expOn[d]) expAn[d] = 1'b0;
        checkOutput($sformatf("v%0d_d%0d_guardAn", k, d), 32'(bus.an), 32'hF);
        checkOutput($sformatf("v%0d_d%0d_guardSeg", k, d), 32'(bus.seg), 32'hFF);
        repeat (5) @(negedge clock);
        checkOutput($sformatf("v%0d_d%0d_an", k, d), 32'(bus.an), 32'(expAn));
        checkOutput($sformatf("v%0d_d%0d_seg", k, d), 32'(bus.seg), 32'(vecs[k].expSegs[8*d +: 8]));
        repeat (5) @(negedge clock);
      end
    end

    waitFrame();
    repeat (20) @(negedge clock);
    applyStimulus(16'h5555);
    repeat (4) @(negedge clock);
    checkOutput("preRstAn", 32'(bus.an), 32'hB);
    checkOutput("preRstPending", 32'(bus.value_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstAn", 32'(bus.an), 32'hF);
    checkOutput("midRstSeg", 32'(bus.seg), 32'hFF);
    checkOutput("midRstFd", 32'(bus.frame_done), 32'd0);
    checkOutput("midRstReady", 32'(bus.value_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("postRstAn", 32'(bus.an), 32'hE);
    checkOutput("postRstSeg", 32'(bus.seg), 32'hC0);
    waitFrame();
    repeat (5) @(negedge clock);
    checkOutput("postRstNoPending", 32'(bus.seg), 32'hC0);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
